psum_output_writer: RTL and testbench
=====================================

Name: psum_output_writer

Overview:
- Output stage directly downstream of the accelerator control unit and the PE array.
- Captures finished partial sums presented on the psum output mux path whenever out_storage_wr_en is high, and buffers them in a small FIFO.
- Streams the buffered sums as sequential word writes, starting at output_base_addr, over a valid/ready write channel toward the M00 AXI master.
- Signals completion once the programmed number of outputs has been written.

Parameters:
- ACC_WIDTH, 32, width of psum from PE array.
- C_M00_AXI_DATA_WIDTH, 32, write data width; must be >= ACC_WIDTH. psum is sign-extended to this width.
- ADDR_WIDTH, 32, byte address width.
- FIFO_DEPTH, 16, buffer entries; power of two, >= 2.

Ports:
- CLK  in  1  clock
- RESETN  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches base address and count
- output_base_addr  in  ADDR_WIDTH  byte address of first output word
- num_outputs  in  16  number of psums to write this job
- psum_in  in  ACC_WIDTH  partial sum from psum out mux
- out_storage_wr_en  in  1  psum_in valid this cycle (push)
- wr_addr  out  ADDR_WIDTH  write byte address
- wr_data  out  C_M00_AXI_DATA_WIDTH  write data
- wr_valid  out  1  write request valid
- wr_ready  in  1  downstream accepts write
- busy  out  1  job in progress (state != IDLE)
- done  out  1  one-cycle pulse at job end
- overflow  out  1  sticky: push dropped because FIFO full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (RESETN=0 at posedge): state IDLE; FIFO emptied; all counters 0; wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, fifo_count=0. A reset mid-job abandons the job; no further writes are issued.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - On start=1: latch addr=output_base_addr and remaining_in=remaining_out=num_outputs; clear overflow.
  - Go to DONE if num_outputs==0, else STREAM.
  - out_storage_wr_en is ignored while IDLE.
- STREAM:
  - Each cycle with out_storage_wr_en=1, push psum_in and decrement remaining_in.
  - When the final push occurs (remaining_in 1->0), go to DRAIN.
- DRAIN:
  - Pushes are ignored.
  - When remaining_out reaches 0 and the FIFO is empty, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start asserted while busy=1 is ignored.
- Write channel:
  - wr_valid is asserted whenever the FIFO is non-empty in STREAM or DRAIN.
  - wr_data = FIFO head, sign-extended.
  - Handshake completes when wr_valid && wr_ready at posedge: pop the FIFO, addr += C_M00_AXI_DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH), remaining_out decrements.
  - While wr_valid=1 and wr_ready=0, wr_addr and wr_data hold stable.
- Latency: a push at posedge N into an empty FIFO gives wr_valid=1 after posedge N (visible in cycle N+1). Throughput is 1 word/cycle with wr_ready held high.
- Full/empty rules:
  - A push when full with a simultaneous pop is accepted.
  - A push when full without a pop is dropped: overflow is set (sticky until next start), remaining_in still decrements, and remaining_out decrements too, so the job terminates.
  - A pop only occurs when the FIFO is non-empty.
- fifo_count updates: +1 on push only, -1 on pop only, unchanged on both or neither.
- overflow is held through DONE/IDLE until next start or reset.

Optional Feature:
- Macro OUT_RELU_EN.
- Defined: each psum is clamped at push time: negative value (MSB=1) stored as 0, non-negative unchanged.
- Undefined: psum stored unmodified (sign-extended).
- No timing difference either way.

Test Plan:
- Reset then idle: RESETN=0 two cycles, then toggle out_storage_wr_en with no start -> wr_valid=0, fifo_count=0, busy=0 throughout.
- Basic job: base=0x1000, num_outputs=4, push 5,-3,7,9 on consecutive cycles, wr_ready=1 -> writes (0x1000,5), (0x1004,0xFFFFFFFD), (0x1008,7), (0x100C,9) on consecutive cycles; done pulses once, one cycle after the last handshake.
- Backpressure: same job with wr_ready=0 for 6 cycles -> wr_addr=0x1000 and wr_data=5 held stable, fifo_count=4; release -> 4 writes in order, done pulse.
- Overflow: FIFO_DEPTH=16, wr_ready=0, num_outputs=18, 18 pushes -> overflow=1 after push 17; release -> exactly 16 writes issued, done asserted, overflow remains 1.
- Zero count and ignored start: num_outputs=0 -> done pulses one cycle after start with no wr_valid; second start while busy during a 4-word job -> ignored, original addresses are used.
- Reset mid-job and ReLU: RESETN=0 after 2 of 4 writes -> wr_valid=0, busy=0 next cycle. With OUT_RELU_EN, pushing -3 -> wr_data=0.

Source files
------------

// File: rtl/psum_output_writer_if.sv
// Write channel from the psum output writer toward the M00 AXI master.
// Carries one word write per wr_valid/wr_ready handshake.
interface psum_output_writer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;

  modport master (output wr_addr, output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_addr, input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/psum_output_writer.sv
// Buffers finished PE-array partial sums in a FIFO and streams them as sequential word writes.
// Build option: define OUT_RELU_EN to clamp negative psums to zero as they enter the FIFO.
module psum_output_writer #(
  parameter int ACC_WIDTH            = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH           = 32,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         output_base_addr,
  input  logic [15:0]                   num_outputs,
  input  logic [ACC_WIDTH-1:0]          psum_in,
  input  logic                          out_storage_wr_en,
  psum_output_writer_if.master          wr_if,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(C_M00_AXI_DATA_WIDTH / 8);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]            state;
  logic [ACC_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           remaining_in;
  logic [15:0]           remaining_out;
  logic                  overflow_q;

  logic                  active;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  wr_valid_int;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [CNT_W-1:0]      count_next;
  logic [15:0]           rem_out_next;
  logic [ACC_WIDTH-1:0]  push_val;

  always_comb begin
`ifdef OUT_RELU_EN
    push_val = psum_in[ACC_WIDTH-1] ? '0 : psum_in;
`else
    push_val = psum_in;
`endif
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle; a dropped
  // push still retires one expected output so the job always terminates.
  always_comb begin
    active       = (state == STREAM) || (state == DRAIN);
    fifo_empty   = (count == '0);
    fifo_full    = (count == DEPTH_C);
    wr_valid_int = active && !fifo_empty;
    pop          = wr_valid_int && wr_if.wr_ready;
    push_req     = (state == STREAM) && out_storage_wr_en;
    push         = push_req && (!fifo_full || pop);
    drop         = push_req && fifo_full && !pop;
    count_next   = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);
    rem_out_next = (pop || drop) ? remaining_out - 16'd1 : remaining_out;
  end

  assign wr_if.wr_valid = wr_valid_int;
  assign wr_if.wr_addr  = addr;
  assign wr_if.wr_data  = wr_valid_int ? C_M00_AXI_DATA_WIDTH'($signed(mem[rd_ptr])) : '0;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign overflow       = overflow_q;
  assign fifo_count     = count;

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= push_val;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      addr          <= '0;
      remaining_in  <= '0;
      remaining_out <= '0;
      overflow_q    <= 1'b0;
    end else begin
      count         <= count_next;
      remaining_out <= rem_out_next;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        addr   <= addr + ADDR_STEP;
      end
      if (push_req)
        remaining_in <= remaining_in - 16'd1;
      if (drop)
        overflow_q <= 1'b1;

      // DRAIN exits on the edge that retires the last word, so done follows it directly.
      case (state)
        IDLE: begin
          if (start) begin
            addr          <= output_base_addr;
            remaining_in  <= num_outputs;
            remaining_out <= num_outputs;
            overflow_q    <= 1'b0;
            state         <= (num_outputs == 16'd0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (push_req && remaining_in == 16'd1)
            state <= DRAIN;
        end
        DRAIN: begin
          if (rem_out_next == 16'd0 && count_next == '0)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_output_writer.sv
// Randomized and directed bench for psum_output_writer, checked against a queue-based job model.
module tb_psum_output_writer;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        start;
  logic [31:0] output_base_addr;
  logic [15:0] num_outputs;
  logic [31:0] psum_in;
  logic        out_storage_wr_en;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  fifo_count;

  psum_output_writer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wr_if ();

  psum_output_writer #(
    .ACC_WIDTH(32), .C_M00_AXI_DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(16)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .start(start), .output_base_addr(output_base_addr),
    .num_outputs(num_outputs), .psum_in(psum_in), .out_storage_wr_en(out_storage_wr_en),
    .wr_if(wr_if), .busy(busy), .done(done), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Job model: 0 idle, 1 collecting, 2 draining, 3 finishing
  int          phase = 0;
  logic [31:0] mq[$];
  logic [31:0] m_addr = '0;
  int          pushes_left = 0;
  int          writes_left = 0;
  logic        m_ovf = 1'b0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          done_seen = 0;
  logic [31:0] basic_vals [4];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] stored_val(input logic [31:0] p);
`ifdef OUT_RELU_EN
    return p[31] ? 32'd0 : p;
`else
    return p;
`endif
  endfunction

  function automatic logic model_valid();
    return (phase == 1 || phase == 2) && mq.size() > 0;
  endfunction

  task automatic checkAll();
    checkOutput("wr_valid", 32'(wr_if.wr_valid), 32'(model_valid()));
    checkOutput("fifo_count", 32'(fifo_count), 32'(mq.size()));
    checkOutput("busy", 32'(busy), 32'(phase != 0));
    checkOutput("done", 32'(done), 32'(phase == 3));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (model_valid()) begin
      checkOutput("wr_addr", wr_if.wr_addr, m_addr);
      checkOutput("wr_data", wr_if.wr_data, mq[0]);
    end
  endtask

  // Advances the model by one clock using the inputs currently driven, then checks the DUT.
  task automatic applyStimulus();
    int old;
    logic hs;
    logic [31:0] v;
    if (wr_if.wr_valid && wr_if.wr_ready) begin
      log_addr.push_back(wr_if.wr_addr);
      log_data.push_back(wr_if.wr_data);
    end
    if (done) done_seen++;
    if (!RESETN) begin
      phase = 0; mq.delete(); m_addr = '0; pushes_left = 0; writes_left = 0; m_ovf = 1'b0;
    end else begin
      old = phase;
      hs  = model_valid() && wr_if.wr_ready;
      if (hs) begin
        void'(mq.pop_front());
        m_addr += 32'd4;
        writes_left--;
      end
      case (old)
        0: if (start) begin
          m_addr = output_base_addr; pushes_left = int'(num_outputs);
          writes_left = int'(num_outputs); m_ovf = 1'b0;
          phase = (num_outputs == 16'd0) ? 3 : 1;
        end
        1: if (out_storage_wr_en) begin
          pushes_left--;
          v = stored_val(psum_in);
          if (mq.size() < 16) mq.push_back(v);
          else begin m_ovf = 1'b1; writes_left--; end
          if (pushes_left == 0) phase = 2;
        end
        2: if (writes_left == 0 && mq.size() == 0) phase = 3;
        default: phase = 0;
      endcase
    end
    @(posedge CLK);
    @(negedge CLK);
    checkAll();
  endtask

  task automatic drive(input logic s, input logic en, input logic [31:0] p, input logic rdy);
    start = s; out_storage_wr_en = en; psum_in = p; wr_if.wr_ready = rdy;
  endtask

  task automatic clearLog();
    log_addr.delete(); log_data.delete(); done_seen = 0;
  endtask

  initial begin
    RESETN = 1'b0; output_base_addr = '0; num_outputs = '0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    basic_vals = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd9};
    @(negedge CLK);
    repeat (2) applyStimulus();
    RESETN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'(i % 2), $urandom, 1'b1);
      applyStimulus();
    end

    // Basic four-word job at full throughput
    clearLog();
    output_base_addr = 32'h1000; num_outputs = 16'd4;
    drive(1'b1, 1'b0, 32'd0, 1'b1); applyStimulus();
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, basic_vals[i], 1'b1); applyStimulus(); end
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b0, 32'd0, 1'b1); applyStimulus(); end
    checkOutput("basic_writes", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      checkOutput("basic_addr", log_addr[i], 32'h1000 + 32'(4 * i));
      checkOutput("basic_data", log_data[i], stored_val(basic_vals[i]));
    end
    checkOutput("basic_done_pulses", 32'(done_seen), 32'd1);

    // Backpressure: six cycles without ready, then release
    clearLog();
    drive(1'b1, 1'b0, 32'd0, 1'b0); applyStimulus();
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, basic_vals[i], 1'b0); applyStimulus(); end
    for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0, 32'd0, 1'b0); applyStimulus(); end
    checkOutput("bp_count", 32'(fifo_count), 32'd4);
    checkOutput("bp_addr", wr_if.wr_addr, 32'h1000);
    checkOutput("bp_data", wr_if.wr_data, 32'd5);
    for (int i = 0; i < 7; i++) begin drive(1'b0, 1'b0, 32'd0, 1'b1); applyStimulus(); end
    checkOutput("bp_writes", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      checkOutput("bp_data_order", log_data[i], stored_val(basic_vals[i]));
    checkOutput("bp_done_pulses", 32'(done_seen), 32'd1);

    // Overflow: eighteen pushes into a sixteen-entry FIFO with no drain
    clearLog();
    output_base_addr = 32'h4000; num_outputs = 16'd18;
    drive(1'b1, 1'b0, 32'd0, 1'b0); applyStimulus();
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b1, $urandom, 1'b0); applyStimulus();
      if (i == 15) checkOutput("ovf_before", 32'(overflow), 32'd0);
      if (i == 16) checkOutput("ovf_after", 32'(overflow), 32'd1);
    end
    for (int i = 0; i < 20; i++) begin drive(1'b0, 1'b0, 32'd0, 1'b1); applyStimulus(); end
    checkOutput("ovf_writes", 32'(log_addr.size()), 32'd16);
    checkOutput("ovf_done_pulses", 32'(done_seen), 32'd1);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Zero-length job, then a start pulse while busy
    clearLog();
    num_outputs = 16'd0;
    drive(1'b1, 1'b0, 32'd0, 1'b1); applyStimulus();
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_ovf_cleared", 32'(overflow), 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b1); applyStimulus();
    output_base_addr = 32'h2000; num_outputs = 16'd4;
    drive(1'b1, 1'b0, 32'd0, 1'b1); applyStimulus();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin output_base_addr = 32'h3000; num_outputs = 16'd2; end
      drive(1'(i == 1), 1'b1, $urandom, 1'b1); applyStimulus();
    end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 32'd0, 1'b1); applyStimulus(); end
    checkOutput("busy_start_writes", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      checkOutput("busy_start_addr", log_addr[i], 32'h2000 + 32'(4 * i));
    checkOutput("zero_and_job_done", 32'(done_seen), 32'd2);

    // Reset after two of four writes
    clearLog();
    output_base_addr = 32'h5000; num_outputs = 16'd4;
    drive(1'b1, 1'b0, 32'd0, 1'b1); applyStimulus();
    for (int i = 0; i < 8 && log_addr.size() < 2; i++) begin
      drive(1'b0, 1'(i < 4), 32'hFFFF_FFFD, 1'b1); applyStimulus();
    end
    RESETN = 1'b0; drive(1'b0, 1'b0, 32'd0, 1'b0); applyStimulus();
    checkOutput("mid_reset_valid", 32'(wr_if.wr_valid), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    RESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 32'd1, 1'b1); applyStimulus(); end
    checkOutput("mid_reset_writes", 32'(log_addr.size()), 32'd2);
    if (log_data.size() > 0) checkOutput("mid_reset_data", log_data[0], stored_val(32'hFFFF_FFFD));

    // Random jobs with random push enables, backpressure and stray start pulses
    for (int j = 0; j < 40; j++) begin
      int thr;
      thr = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        RESETN = 1'b0; drive(1'b0, 1'b1, $urandom, 1'b1); applyStimulus(); RESETN = 1'b1;
      end
      output_base_addr = (j == 0) ? 32'hFFFF_FFF8 : $urandom;
      num_outputs = 16'($urandom_range(0, 20));
      drive(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b1); applyStimulus();
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          output_base_addr = $urandom; num_outputs = 16'($urandom_range(0, 20));
        end
        drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), $urandom,
              1'(int'($urandom_range(0, 3)) >= thr));
        applyStimulus();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
